// File: rtl/segment_display_pkg.sv
// segment_display_pkg: segment bit positions, blank pattern and hex-to-segment decode
package segment_display_pkg;
  localparam int SEG_A = 7;
  localparam int SEG_DP = 0;
  localparam logic [7:0] SEG_OFF = 8'h00;
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] p;
    case (nibble)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    hex_to_seg = SEG_OFF;
    hex_to_seg[SEG_A -: 7] = p;
  endfunction
endpackage

// File: rtl/segment_scan_timer.sv
// segment_scan_timer: step/phase/digit/blink-frame counter chain that paces the scan
module segment_scan_timer #(
  parameter int STEP_CYCLES = 2,
  parameter int PHASE_BITS = 2,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [PHASE_BITS-1:0] phase,
  output logic dead,
  output logic frame_latch,
  output logic blink_off
);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [SW-1:0] step_cnt;
  logic [BW-1:0] blink_frame_cnt;
  logic step_last, slot_last, frame_last, blink_last;
  assign step_last = step_cnt == SW'(STEP_CYCLES - 1);
  assign slot_last = step_last && &phase;
  assign frame_last = slot_last && digit_idx == DW'(NUM_DIGITS - 1);
  assign blink_last = blink_frame_cnt == BW'(BLINK_FRAMES - 1);
  assign dead = phase == '0 && step_cnt == '0;
  assign frame_latch = dead && digit_idx == '0;
  // Ripple-carry counter chain; phase wraps naturally since STEPS is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      phase <= '0;
      digit_idx <= '0;
      blink_frame_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      step_cnt <= step_last ? '0 : step_cnt + 1'b1;
      if (step_last) phase <= phase + 1'b1;
      if (slot_last) digit_idx <= frame_last ? '0 : digit_idx + 1'b1;
      if (frame_last) blink_frame_cnt <= blink_last ? '0 : blink_frame_cnt + 1'b1;
      if (frame_last && blink_last) blink_off <= ~blink_off;
    end
  end
endmodule

// File: rtl/segment_display_scanner.sv
// segment_display_scanner: multiplexed 7-segment driver with PWM, blink, raw mode and frame-latched inputs
module segment_display_scanner
  import segment_display_pkg::*;
#(
  parameter int CLK_RATE_HZ = 390625,
  parameter int NUM_DIGITS = 6,
  parameter int REFRESH_RATE_HZ = 80,
  parameter int BRIGHTNESS_BITS = 3,
  parameter int BLINK_RATE_HZ = 2,
  parameter int SEGMENTS_ACTIVE_LOW = 0,
  parameter int DIGITS_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_DIGITS*4-1:0] data,
  input  logic [NUM_DIGITS*8-1:0] raw_segments,
  input  logic [NUM_DIGITS-1:0] raw_mode_mask,
  input  logic [NUM_DIGITS-1:0] digit_enable_mask,
  input  logic [NUM_DIGITS-1:0] decimal_point_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [BRIGHTNESS_BITS-1:0] brightness,
  output logic [7:0] led_segments,
  output logic [NUM_DIGITS-1:0] led_digit_enable,
  output logic frame_start
);
  localparam int SLOT_CYCLES = CLK_RATE_HZ / (REFRESH_RATE_HZ * NUM_DIGITS);
  localparam int STEPS = 2 ** BRIGHTNESS_BITS;
  localparam int STEP_CYCLES = SLOT_CYCLES / STEPS;
  localparam int BLINK_FRAMES = REFRESH_RATE_HZ / (2 * BLINK_RATE_HZ);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [7:0] SEG_POL = SEGMENTS_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = DIGITS_ACTIVE_LOW != 0 ? '1 : '0;
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("segment_display_scanner: STEP_CYCLES must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("segment_display_scanner: BLINK_FRAMES must be at least 1");
  end
  logic [DW-1:0] digit_idx;
  logic [BRIGHTNESS_BITS-1:0] phase;
  logic dead, frame_latch, blink_off, lit;
  logic [7:0] seg;
  logic [NUM_DIGITS*4-1:0] sh_data;
  logic [NUM_DIGITS*8-1:0] sh_raw;
  logic [NUM_DIGITS-1:0] sh_raw_mode, sh_en, sh_dp, sh_blink;
  logic [BRIGHTNESS_BITS-1:0] sh_bright;
  segment_scan_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .PHASE_BITS(BRIGHTNESS_BITS),
    .NUM_DIGITS(NUM_DIGITS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .digit_idx(digit_idx),
    .phase(phase),
    .dead(dead),
    .frame_latch(frame_latch),
    .blink_off(blink_off)
  );
  // Shadow copies of all inputs, refreshed only at frame start so a frame never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_data <= '0;
      sh_raw <= '0;
      sh_raw_mode <= '0;
      sh_en <= '0;
      sh_dp <= '0;
      sh_blink <= '0;
      sh_bright <= '0;
    end else if (frame_latch) begin
      sh_data <= data;
      sh_raw <= raw_segments;
      sh_raw_mode <= raw_mode_mask;
      sh_en <= digit_enable_mask;
      sh_dp <= decimal_point_mask;
      sh_blink <= blink_mask;
      sh_bright <= brightness;
    end
  end
  // Lit decision and segment pattern for the digit currently being scanned
  always_comb begin
    lit = sh_en[digit_idx] && phase <= sh_bright && !(sh_blink[digit_idx] && blink_off) && !dead;
    seg = sh_raw_mode[digit_idx] ? sh_raw[digit_idx*8 +: 8]
        : hex_to_seg(sh_data[digit_idx*4 +: 4]) | (8'(sh_dp[digit_idx]) << SEG_DP);
  end
  // Registered pin drivers; polarity is applied last so blanking follows the board's sense
  always_ff @(posedge clk) begin
    if (reset) begin
      led_segments <= SEG_POL;
      led_digit_enable <= DIG_POL;
      frame_start <= 1'b0;
    end else begin
      led_segments <= (lit ? seg : SEG_OFF) ^ SEG_POL;
      led_digit_enable <= (lit ? NUM_DIGITS'(1) << digit_idx : '0) ^ DIG_POL;
      frame_start <= frame_latch;
    end
  end
endmodule

// File: doc/segment_display_scanner.md
# segment_display_scanner

Second-generation multiplexed 7-segment LED driver: scans `NUM_DIGITS` digits, per digit either hex-decoding a nibble or passing raw segment bits, with PWM brightness, per-digit blink, selectable output polarity and tear-free frame latching. The whole design runs on `clk` using clock enables; there is no derived clock. The block sits between front-panel or debug logic and the board's LED pins.

## Interface
- `CLK_RATE_HZ`, 390625, `clk` frequency.
- `NUM_DIGITS`, 6, number of digits, at least 2.
- `REFRESH_RATE_HZ`, 80, full-display frames per second.
- `BRIGHTNESS_BITS`, 3, width of `brightness`.
- `BLINK_RATE_HZ`, 2, blink on/off cycles per second.
- `SEGMENTS_ACTIVE_LOW`, 0, 1 inverts `led_segments`.
- `DIGITS_ACTIVE_LOW`, 0, 1 inverts `led_digit_enable`.
- Derived: `SLOT_CYCLES` = `CLK_RATE_HZ` / (`REFRESH_RATE_HZ`·`NUM_DIGITS`); `STEPS` = 2^`BRIGHTNESS_BITS`; `STEP_CYCLES` = `SLOT_CYCLES`/`STEPS`; `BLINK_FRAMES` = `REFRESH_RATE_HZ`/(2·`BLINK_RATE_HZ`).
- Elaboration `$error` if `STEP_CYCLES` < 1 or `BLINK_FRAMES` < 1.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous reset, active-high.
- `data` in `NUM_DIGITS`·4: hex nibbles; nibble i goes to digit i.
- `raw_segments` in `NUM_DIGITS`·8: raw a..g,dp pattern per digit, a in bit 7.
- `raw_mode_mask` in `NUM_DIGITS`: 1 = digit shows `raw_segments` instead of decoded nibble.
- `digit_enable_mask` in `NUM_DIGITS`: 0 blanks the digit.
- `decimal_point_mask` in `NUM_DIGITS`: ORs in dp; ignored in raw mode.
- `blink_mask` in `NUM_DIGITS`: digit blanks during the blink-off phase.
- `brightness` in `BRIGHTNESS_BITS`: duty = (`brightness`+1)/`STEPS`.
- `led_segments` out 8: a..g,dp with a in bit 7; registered.
- `led_digit_enable` out `NUM_DIGITS`: one-hot or zero; registered.
- `frame_start` out 1: one-cycle pulse marking the first output cycle of digit 0.

## Operation
- **Counters.** Counter chain: `step_cnt` 0..`STEP_CYCLES`-1, then `phase` 0..`STEPS`-1, then `digit_idx` 0..`NUM_DIGITS`-1 wrapping to 0, then `blink_frame_cnt` 0..`BLINK_FRAMES`-1. `blink_off` toggles each time `blink_frame_cnt` wraps.
- **Frame latch.** All inputs are captured into shadow registers once per frame, on the cycle the counters enter digit 0, phase 0, step 0. Input changes mid-frame are invisible until the next frame.
- **Lit condition.** Digit i is lit when all of the following hold: `digit_idx`==i; shadow enable[i]; `phase` <= shadow brightness; not (shadow blink[i] and `blink_off`); not the dead cycle.
- **Dead cycle.** The dead cycle is `phase`==0 and `step_cnt`==0. It is the anti-ghosting gap at every digit change.
- **Segment selection.** Segments = raw byte if raw_mode[i], else hex decode of nibble i OR dp[i]. When no digit is lit, segments are all-off.
- **Polarity.** Polarity inversion is applied last, to both output buses.
- **Brightness.** At maximum `brightness` a digit is on for `SLOT_CYCLES`-1 cycles per slot; at 0 it is on for `STEP_CYCLES`-1.

## Timing
- **Reset.** Counters, shadows and `blink_off` are cleared. `led_segments`, `led_digit_enable` and `frame_start` go to inactive level on the edge where `reset` is sampled high: all-0, or all-1 for active-low parameters; `frame_start`=0. Reset mid-frame aborts the scan immediately.
- **First frame.** The first cycle with `reset` low is the first frame-latch cycle. Outputs reflect counter state with 1-cycle latency. `frame_start` is high on the cycle after each latch, which is the digit-0 dead cycle on the outputs.
- **Slot and frame length.** Slot length is exactly `STEP_CYCLES`·`STEPS` cycles. Frame length is `NUM_DIGITS` slots.
- **Blink timing.** `blink_off` changes only at frame boundaries.
- **Hex decode.** Patterns, a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

## Structure
- Package `segment_display_pkg`: hex-to-segment function, segment bit-index constants, all-off constant.
- Sub-module `segment_scan_timer`: owns the counter chain and emits `digit_idx`, `phase`, `dead`, `frame_latch` and `blink_off`. The top level holds the shadows, decode and output registers.

## Test plan
Bench parameters: `CLK_RATE_HZ`=1920, `NUM_DIGITS`=4, `REFRESH_RATE_HZ`=60, `BRIGHTNESS_BITS`=2, `BLINK_RATE_HZ`=15. This gives `SLOT_CYCLES`=8, `STEP_CYCLES`=2, `BLINK_FRAMES`=2.
- **Hex scan.** `data`=16'h3A0F, all enabled, `brightness`=3 → per 8-cycle slot: 1 dead cycle, then 7 cycles of F(10001110), 0(11111100), A(11101110), 3(11110010). `led_digit_enable` steps 0001→0010→0100→1000; `frame_start` every 32 cycles.
- **Brightness.** `brightness`=0 → each digit lit 1 cycle per slot (cycle 1), off cycles 2–7.
- **Tear-free latch.** Change `data` to 16'h1111 mid-frame → the current frame finishes with old values; the next frame shows 1s.
- **Raw mode, dp and polarity.** `raw_mode_mask`=4'b0010 with `raw_segments` byte1=8'h55, `decimal_point_mask`=4'b0011; `SEGMENTS_ACTIVE_LOW`=1 → digit0 shows ~(11111101), digit1 shows ~8'h55 (dp ignored), and idle segments are 8'hFF.
- **Blink.** `blink_mask`=4'b0100 → digit2 is lit in frames 0–1, dark in frames 2–3, lit in 4–5.
- **Reset mid-frame.** Assert `reset` for 1 cycle mid-slot → outputs are inactive on the next cycle. Scan restarts at digit 0 with `frame_start` 2 cycles after the reset cycle, and `blink_off`=0.
